// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: SPI responder emulating an 8-channel 12-bit A/D converter.
// Ports: clk/rst (async, active-high); SS_n, SCLK, MOSI in, MISO out (MSB first);
// lft_ld_in/rght_ld_in/steer_pot_in/batt_in are the samples for channels 0/4/5/6;
// chnl is the selected channel; cmd_vld, frm_err, cmd_err are one-cycle pulses.
// Define A2D_RESP_CHK_EN to flag accepted frames with non-zero reserved bits on cmd_err.
module a2d_spi_resp #(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [11:0] UNMAPPED_VAL = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] lft_ld_in,
  input  logic [11:0] rght_ld_in,
  input  logic [11:0] steer_pot_in,
  input  logic [11:0] batt_in,
  output logic [2:0]  chnl,
  output logic        cmd_vld,
  output logic        frm_err,
  output logic        cmd_err
);
  typedef enum logic {IDLE, ACTIVE} state_t;
`ifdef A2D_RESP_CHK_EN
  localparam int RXW = 16;
`else
  // Without the reserved-bit check only bits [13:11] matter, so the top two are never kept.
  localparam int RXW = 14;
`endif
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ss_q, ss_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic                   ss_prev_q, sclk_prev_q;
  logic [15:0]            tx_q, tx_d;
  logic [RXW-1:0]         rx_q, rx_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [2:0]             chnl_q, chnl_d;
  logic                   cmd_vld_q, cmd_vld_d, frm_err_q, frm_err_d, cmd_err_q, cmd_err_d;
  logic                   ss_s, sclk_s, mosi_s, ss_fall, ss_rise, sclk_rise, sclk_fall, bad;
  logic [11:0]            smp;

  assign ss_s      = ss_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign ss_fall   = ss_prev_q & ~ss_s;
  assign ss_rise   = ~ss_prev_q & ss_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  assign smp = chnl_q == 3'd0 ? lft_ld_in :
               chnl_q == 3'd4 ? rght_ld_in :
               chnl_q == 3'd5 ? steer_pot_in :
               chnl_q == 3'd6 ? batt_in : UNMAPPED_VAL;
`ifdef A2D_RESP_CHK_EN
  assign bad = (|rx_q[15:14]) | (|rx_q[10:0]);
`else
  assign bad = 1'b0;
`endif

  always_comb begin
    ss_d      = {ss_q[SYNC_STAGES-2:0], SS_n};
    sclk_d    = {sclk_q[SYNC_STAGES-2:0], SCLK};
    mosi_d    = {mosi_q[SYNC_STAGES-2:0], MOSI};
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    cnt_d     = cnt_q;
    chnl_d    = chnl_q;
    cmd_vld_d = 1'b0;
    frm_err_d = 1'b0;
    cmd_err_d = 1'b0;
    // A fall while already active is a glitch and simply restarts the frame.
    if (ss_fall) begin
      state_d = ACTIVE;
      tx_d    = {4'h0, smp};
      cnt_d   = 5'd0;
    end else if (state_q == ACTIVE) begin
      if (ss_rise) begin
        state_d   = IDLE;
        frm_err_d = cnt_q != 5'd16;
        cmd_vld_d = cnt_q == 5'd16 && !bad;
        cmd_err_d = cnt_q == 5'd16 && bad;
        chnl_d    = cmd_vld_d ? rx_q[13:11] : chnl_q;
      end else if (sclk_rise) begin
        rx_d  = {rx_q[RXW-2:0], mosi_s};
        cnt_d = cnt_q == 5'd17 ? cnt_q : cnt_q + 5'd1;
      end else if (sclk_fall && cnt_q != 5'd0) begin
        tx_d = {tx_q[14:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_q        <= '1;
      sclk_q      <= '1;
      mosi_q      <= '1;
      ss_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b1;
      state_q     <= IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      chnl_q      <= '0;
      cmd_vld_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      ss_q        <= ss_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ss_prev_q   <= ss_s;
      sclk_prev_q <= sclk_s;
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      chnl_q      <= chnl_d;
      cmd_vld_q   <= cmd_vld_d;
      frm_err_q   <= frm_err_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign MISO    = tx_q[15];
  assign chnl    = chnl_q;
  assign cmd_vld = cmd_vld_q;
  assign frm_err = frm_err_q;
  assign cmd_err = cmd_err_q;
endmodule

// File: tb/tb_a2d_spi_resp.sv
// tb_a2d_spi_resp: directed self-checking bench for a2d_spi_resp.
module tb_a2d_spi_resp;
  logic        clk = 1'b0, rst = 1'b1, SS_n = 1'b1, SCLK = 1'b1, MOSI = 1'b1;
  logic        MISO, cmd_vld, frm_err, cmd_err;
  logic [11:0] lft_ld_in = '0, rght_ld_in = '0, steer_pot_in = '0, batt_in = '0;
  logic [2:0]  chnl;
  int          checks = 0, errors = 0;
  int          vld_n = 0, ferr_n = 0, cerr_n = 0;

  a2d_spi_resp dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .lft_ld_in(lft_ld_in), .rght_ld_in(rght_ld_in), .steer_pot_in(steer_pot_in),
    .batt_in(batt_in), .chnl(chnl), .cmd_vld(cmd_vld), .frm_err(frm_err), .cmd_err(cmd_err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    vld_n  <= vld_n + int'(cmd_vld);
    ferr_n <= ferr_n + int'(frm_err);
    cerr_n <= cerr_n + int'(cmd_err);
  end

  task automatic spi_xfer(input logic [15:0] cmd, input int n, output logic [15:0] rx);
    rx = '0;
    SS_n = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      SCLK = 1'b0;
      MOSI = cmd[15-i];
      repeat (16) @(negedge clk);
      rx = {rx[14:0], MISO};
      SCLK = 1'b1;
      repeat (16) @(negedge clk);
    end
    SS_n = 1'b1;
    MOSI = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] rx;
    int v0, f0;
    repeat (5) @(negedge clk);
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL rst_miso got %b want 0", MISO); end
    checks++; if (chnl !== 3'd0) begin errors++; $display("FAIL rst_chnl got %0d want 0", chnl); end
    rst = 1'b0;
    rght_ld_in = 12'hA5C;
    spi_xfer(16'h2000, 16, rx);
    SS_n = 1'b0;
    repeat (16) @(negedge clk);
    SCLK = 1'b0;
    repeat (16) @(negedge clk);
    SCLK = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    SS_n = 1'b1;
    SCLK = 1'b1;
    repeat (4) @(negedge clk);
    v0 = vld_n;
    f0 = ferr_n;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL midrst_miso got %b want 0", MISO); end
    checks++; if (chnl !== 3'd0) begin errors++; $display("FAIL midrst_chnl got %0d want 0", chnl); end
    checks++; if (vld_n != v0 || ferr_n != f0) begin errors++; $display("FAIL midrst_pulses got vld %0d ferr %0d want 0 0", vld_n - v0, ferr_n - f0); end
  endtask

  task automatic test_ch4();
    logic [15:0] rx;
    int v0;
    v0 = vld_n;
    spi_xfer(16'h2000, 16, rx);
    checks++; if (vld_n - v0 != 1) begin errors++; $display("FAIL ch4_vld got %0d want 1", vld_n - v0); end
    checks++; if (chnl !== 3'd4) begin errors++; $display("FAIL ch4_chnl got %0d want 4", chnl); end
    spi_xfer(16'h2000, 16, rx);
    checks++; if (rx !== 16'h0A5C) begin errors++; $display("FAIL ch4_read got %h want 0a5c", rx); end
  endtask

  task automatic test_round_robin();
    logic [15:0] rx;
    logic [15:0] cmds [5] = '{16'h0000, 16'h2000, 16'h2800, 16'h3000, 16'h0000};
    logic [15:0] exps [5] = '{16'h0111, 16'h0444, 16'h0555, 16'h0666, 16'h0111};
    lft_ld_in = 12'h111; rght_ld_in = 12'h444; steer_pot_in = 12'h555; batt_in = 12'h666;
    for (int i = 0; i < 5; i++) begin
      spi_xfer(cmds[i], 16, rx);
      spi_xfer(cmds[i], 16, rx);
      checks++; if (rx !== exps[i]) begin errors++; $display("FAIL rr_%0d got %h want %h", i, rx, exps[i]); end
    end
  endtask

  task automatic test_short_frame();
    logic [15:0] rx;
    int v0, f0;
    spi_xfer(16'h2800, 16, rx);
    v0 = vld_n;
    f0 = ferr_n;
    spi_xfer(16'h0000, 9, rx);
    checks++; if (ferr_n - f0 != 1) begin errors++; $display("FAIL short_ferr got %0d want 1", ferr_n - f0); end
    checks++; if (vld_n != v0) begin errors++; $display("FAIL short_vld got %0d want 0", vld_n - v0); end
    checks++; if (chnl !== 3'd5) begin errors++; $display("FAIL short_chnl got %0d want 5", chnl); end
  endtask

  task automatic test_mid_change();
    logic [15:0] rx;
    batt_in = 12'h0F0;
    spi_xfer(16'h3000, 16, rx);
    fork
      spi_xfer(16'h3000, 16, rx);
      begin
        repeat (200) @(negedge clk);
        batt_in = 12'hFFF;
      end
    join
    checks++; if (rx !== 16'h00F0) begin errors++; $display("FAIL mid_snap got %h want 00f0", rx); end
    spi_xfer(16'h3000, 16, rx);
    checks++; if (rx !== 16'h0FFF) begin errors++; $display("FAIL mid_next got %h want 0fff", rx); end
  endtask

  task automatic test_reserved();
    logic [15:0] rx;
    int v0, c0;
    spi_xfer(16'h2800, 16, rx);
    v0 = vld_n;
    c0 = cerr_n;
    spi_xfer(16'h4000, 16, rx);
`ifdef A2D_RESP_CHK_EN
    checks++; if (cerr_n - c0 != 1 || vld_n != v0) begin errors++; $display("FAIL rsv_pulse got cerr %0d vld %0d want 1 0", cerr_n - c0, vld_n - v0); end
    checks++; if (chnl !== 3'd5) begin errors++; $display("FAIL rsv_chnl got %0d want 5", chnl); end
`else
    checks++; if (vld_n - v0 != 1 || cerr_n != c0) begin errors++; $display("FAIL rsv_pulse got vld %0d cerr %0d want 1 0", vld_n - v0, cerr_n - c0); end
    checks++; if (chnl !== 3'd0) begin errors++; $display("FAIL rsv_chnl got %0d want 0", chnl); end
`endif
  endtask

  initial begin
    test_reset();
    test_ch4();
    test_round_robin();
    test_short_frame();
    test_mid_change();
    test_reserved();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/a2d_spi_resp.md
# a2d_spi_resp

Synthesizable SPI responder that emulates the external 8-channel, 12-bit A/D converter as seen from the A2D interface's SPI initiator. It decodes the channel field of each 16-bit command word and returns the 12-bit sample of the previously selected channel on the next transaction. It is used as the A/D model in full-chip benches and as an FPGA loopback target. Sample values come from parallel input ports rather than a converter core.

## Interface
Parameters:
- SYNC_STAGES, 2: metastability flops on SS_n, SCLK and MOSI before edge detection; legal range 2–3.
- UNMAPPED_VAL, 12'h000: value returned for channels 1, 2, 3 and 7.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- SS_n  in  1  slave select, active low, driven by the initiator.
- SCLK  in  1  serial clock from the initiator; idles high.
- MOSI  in  1  serial data from the initiator, MSB first.
- MISO  out  1  serial data to the initiator, MSB first.
- lft_ld_in  in  12  sample returned for channel 0.
- rght_ld_in  in  12  sample returned for channel 4.
- steer_pot_in  in  12  sample returned for channel 5.
- batt_in  in  12  sample returned for channel 6.
- chnl  out  3  currently selected channel.
- cmd_vld  out  1  one-cycle pulse when a complete 16-bit frame has been accepted.
- frm_err  out  1  one-cycle pulse when SS_n deasserts after any rise count other than 16.
- cmd_err  out  1  one-cycle pulse on a reserved-bit violation (only when A2D_RESP_CHK_EN is defined).

## Operation
- SS_n, SCLK and MOSI pass through SYNC_STAGES flops. One further flop stage provides edge detection (ss_fall, ss_rise, sclk_rise, sclk_fall).
- The state machine has two states.
  - IDLE → ACTIVE on ss_fall.
  - ACTIVE → IDLE on ss_rise.
  - Any other event in IDLE is ignored.
- On ss_fall:
  - tx_shft[15:0] loads {4'h0, sample[chnl]}. The sample is snapshotted at this point; changes to the inputs mid-frame are not seen.
  - bit_cnt clears to 0.
- In ACTIVE, on sclk_rise:
  - rx_shft shifts left and takes synchronized MOSI into bit 0.
  - bit_cnt increments and saturates at 17.
- In ACTIVE, on sclk_fall with bit_cnt ≥ 1: tx_shft shifts left and fills with 0. The falling edge before the first rise is ignored, so bit 15 stays presented until the first rise.
- MISO is always driven as tx_shft[15]. It is never tri-stated.
- On ss_rise:
  - If bit_cnt == 16, the frame is accepted: chnl ← rx_shft[13:11] and cmd_vld pulses.
  - Otherwise frm_err pulses, chnl holds, and rx_shft is discarded.
- Channel mapping:
  - 0 → lft_ld_in
  - 4 → rght_ld_in
  - 5 → steer_pot_in
  - 6 → batt_in
  - all other channels → UNMAPPED_VAL
- A response always reflects the chnl value as it stood at that frame's ss_fall. The usual two-transaction sequence is therefore: the command frame selects the channel, and the following frame returns its sample.

## Timing
- Reset values: state=IDLE, chnl=0, tx_shft=0 (so MISO=0), rx_shft=0, bit_cnt=0, cmd_vld=0, frm_err=0, cmd_err=0. All synchronizer flops reset high, so SS_n and SCLK read as idle.
- Input-to-edge-detect latency is SYNC_STAGES+1 clk.
- SCLK high and low phases must each be ≥ SYNC_STAGES+2 clk. The initiator's clk/32 SCLK satisfies this.
- The first SCLK fall must come ≥ 1 clk after ss_fall detection.
- cmd_vld, frm_err and cmd_err assert in the cycle after ss_rise is detected. chnl updates in the same cycle.
- If ss_rise and sclk_rise are detected in the same cycle, the ss_rise wins and that rise is not counted.
- If ss_fall is detected while in ACTIVE (a glitch), the frame restarts with a reload and bit_cnt=0, and no pulse is generated.
- An asserted rst mid-frame aborts the frame immediately to the reset values. The partial frame produces no pulses after rst deasserts.

## Configuration
- A2D_RESP_CHK_EN defined: an accepted frame with rx_shft[15:14] ≠ 0 or rx_shft[10:0] ≠ 0 pulses cmd_err instead of cmd_vld, and chnl holds.
- A2D_RESP_CHK_EN undefined: only bits [13:11] are decoded, and cmd_err is tied to 0.

## Test plan
- Reset check: assert rst mid-frame, then release. Required: MISO=0 and chnl=0, with no cmd_vld or frm_err pulse afterwards.
- Channel 4 readback with rght_ld_in=12'hA5C:
  - Frame 1: send 16'h2000. Required: cmd_vld pulses and chnl=4.
  - Frame 2: send 16'h2000. Required: the initiator receives 16'h0A5C.
- Round robin with inputs 12'h111, 12'h444, 12'h555 and 12'h666 on channels 0, 4, 5, 6. Send command/read pairs for channels 0, 4, 5, 6, then 0 again. Required: the read frames return 16'h0111, 16'h0444, 16'h0555, 16'h0666, 16'h0111 in that order.
- Short frame: select channel 5, then send a frame of only 9 SCLK rises. Required: frm_err pulses once, no cmd_vld pulse, chnl stays 5.
- Mid-frame input change: change batt_in from 12'h0F0 to 12'hFFF while a channel-6 read frame is in progress. Required: the frame returns 16'h00F0, and the next frame returns 16'h0FFF.
- Reserved bits: send 16'h4000 with A2D_RESP_CHK_EN defined. Required: cmd_err pulses and chnl holds. With the macro undefined, the same frame gives a cmd_vld pulse and chnl=0.
